// File: rtl/outer_prod_row_reducer_if.sv
// Handshake bundle for outer_prod_row_reducer: element stream in, row sums out.
// slave = reducer side, master = stream source / sum consumer side.
interface outer_prod_row_reducer_if #(
   parameter int DW    = 8,
   parameter int SUM_W = 12
);
   logic             in_valid;
   logic [DW-1:0]    in_data;
   logic             out_valid;
   logic [SUM_W-1:0] out_sum;
   logic [3:0]       out_row;
   logic             out_ready;
   logic             frame_done;
   logic             busy;
   logic             ovf_err;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_sum, out_row,
      input  frame_done, busy, ovf_err
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_sum, out_row,
      output frame_done, busy, ovf_err
   );
endinterface

// File: rtl/outer_prod_row_reducer.sv
// Reduces each row of a 16x16 outer-product stream to a 12-bit sum and buffers
// the sums in a small FIFO. Ports: clk, rst_n (async low), io (slave bundle).
module outer_prod_row_reducer #(
   parameter int N_DIM     = 16,
   parameter int DW        = 8,
   parameter int SUM_W     = 12,
   parameter int BUF_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   outer_prod_row_reducer_if.slave   io
);
   localparam int CW = $clog2(N_DIM);
   localparam int AW = $clog2(BUF_DEPTH);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state_q;
   logic [CW-1:0]    col_q;
   logic [CW-1:0]    row_q;
   logic [SUM_W-1:0] acc_q;
   logic [SUM_W-1:0] sum_mem_q [BUF_DEPTH];
   logic [CW-1:0]    row_mem_q [BUF_DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             fd_q;
   logic             ovf_q;

   logic             col_last;
   logic             row_last;
   logic [SUM_W-1:0] acc_d;
   logic             push;
   logic             pop;
   logic             empty;
   logic             full;
   logic             wr_en;

   assign col_last = (col_q == CW'(N_DIM - 1));
   assign row_last = (row_q == CW'(N_DIM - 1));

   // Column 0 restarts the row sum instead of adding to the previous row.
   assign acc_d = ((col_q == '0) ? '0 : acc_q) + SUM_W'(io.in_data);

   assign push  = io.in_valid && col_last;
   assign empty = (wr_q == rd_q);
   // Extra pointer MSB distinguishes full from empty.
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && io.out_ready;
   // A full FIFO still takes the push if the head leaves on the same edge.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         acc_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         fd_q    <= 1'b0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < BUF_DEPTH; k++) begin
            sum_mem_q[k] <= '0;
            row_mem_q[k] <= '0;
         end
      end else begin
         fd_q <= io.in_valid && col_last && row_last;

         if (io.in_valid) begin
            acc_q <= acc_d;
            col_q <= col_q + 1'b1;
            if (col_last) begin
               row_q <= row_q + 1'b1;
            end
         end

         unique case (state_q)
            IDLE: begin
               if (io.in_valid) begin
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               if (io.in_valid && col_last && row_last) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (wr_en) begin
            sum_mem_q[wr_q[AW-1:0]] <= acc_d;
            row_mem_q[wr_q[AW-1:0]] <= row_q;
            wr_q <= wr_q + 1'b1;
         end else if (push) begin
            ovf_q <= 1'b1;
         end

         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
      end
   end

   assign io.out_valid  = !empty;
   assign io.out_sum    = sum_mem_q[rd_q[AW-1:0]];
   assign io.out_row    = 4'(row_mem_q[rd_q[AW-1:0]]);
   assign io.frame_done = fd_q;
   assign io.busy       = (state_q == ACCUM);
   assign io.ovf_err    = ovf_q;
endmodule

// File: tb/tb_outer_prod_row_reducer.sv
// Scoreboard bench for outer_prod_row_reducer: random-gapped frames checked
// against row sums computed directly from the generated A/B vectors.
module tb_outer_prod_row_reducer;
   typedef struct packed {
      logic [3:0]  row;
      logic [11:0] sum;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   outer_prod_row_reducer_if ifc ();

   outer_prod_row_reducer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (ifc.slave)
   );

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   ovf_bad = 0;
   int   fd_cnt = 0;
   int   rmode = 0;
   bit   exp_ovf_nxt = 1'b0;
   bit   exp_ovf = 1'b0;

   task automatic check(input string name, input longint act,
                        input longint req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   // Sticky overflow expectation becomes visible after the edge that drops.
   always @(posedge clk) exp_ovf <= rst_n ? exp_ovf_nxt : 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (ifc.frame_done) fd_cnt++;
            if (ifc.ovf_err !== exp_ovf) ovf_bad++;
            if (ifc.out_valid && ifc.out_ready) begin
               if (q.size() == 0) begin
                  n_chk++;
                  $display("FAIL out_unexpected: row %0d sum %0d, none expected",
                           ifc.out_row, ifc.out_sum);
               end else begin
                  e = q.pop_front();
                  check("out_row", ifc.out_row, e.row);
                  check("out_sum", ifc.out_sum, e.sum);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1);
   end

   // One clock of stimulus; the model FIFO decides push vs drop using its
   // own occupancy before this edge's pop.
   task automatic step(input bit v, input logic [7:0] d, input bit push,
                       input exp_t x);
      bit pop_now;
      @(negedge clk);
      ifc.in_valid = v;
      ifc.in_data  = d;
      case (rmode)
         0: ifc.out_ready = 1'b1;
         1: ifc.out_ready = 1'b0;
         2: ifc.out_ready = 1'($urandom_range(0, 1));
         default: ifc.out_ready = v && push && (x.row == 4'd4);
      endcase
      if (v && push) begin
         pop_now = (q.size() > 0) && ifc.out_ready;
         if (q.size() >= 4 && !pop_now) exp_ovf_nxt = 1'b1;
         else q.push_back(x);
      end
   endtask

   task automatic send_frame(input int mode, input int duty, input int nelem,
                             input bit chk_busy);
      logic [7:0] c[256];
      int   a[16];
      int   b[16];
      int   rs[16];
      int   e;
      int   fd0;
      int   busy_bad;
      bit   started;
      bit   v;
      exp_t x;
      e = 0;
      fd0 = fd_cnt;
      busy_bad = 0;
      started = 1'b0;
      for (int i = 0; i < 16; i++) begin
         a[i] = (mode == 0) ? 1 : (mode == 1) ? 15 : int'($urandom_range(0, 15));
         b[i] = (mode == 0) ? i : (mode == 1) ? 15 : int'($urandom_range(0, 15));
      end
      for (int i = 0; i < 16; i++) begin
         rs[i] = 0;
         for (int j = 0; j < 16; j++) begin
            c[i*16+j] = 8'(a[i] * b[j]);
            rs[i] += a[i] * b[j];
         end
      end
      while (e < nelem) begin
         v = ($urandom_range(0, 99) < duty);
         x.row = 4'(e / 16);
         x.sum = 12'(rs[e/16]);
         step(v, v ? c[e] : 8'h00, (e % 16) == 15, x);
         if (chk_busy && started && ifc.busy !== 1'b1) busy_bad++;
         if (v) begin
            if (e == 0) started = 1'b1;
            e++;
         end
      end
      if (nelem == 256) begin
         step(1'b0, 8'h00, 1'b0, '0);
         check("busy_after_frame", ifc.busy, 0);
         check("frame_done_now", ifc.frame_done, 1);
         if (chk_busy) check("busy_span", busy_bad, 0);
         step(1'b0, 8'h00, 1'b0, '0);
         step(1'b0, 8'h00, 1'b0, '0);
         check("frame_done_pulses", fd_cnt - fd0, 1);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && q.size() > 0; k++) begin
         step(1'b0, 8'h00, 1'b0, '0);
      end
      check("drain_left", q.size(), 0);
      check("out_valid_drained", ifc.out_valid, 0);
   endtask

   task automatic do_reset(input bit chk);
      @(negedge clk);
      rst_n = 1'b0;
      ifc.in_valid = 1'b0;
      ifc.in_data  = 8'h00;
      ifc.out_ready = 1'b1;
      #1;
      if (chk) begin
         check("rst_out_valid", ifc.out_valid, 0);
         check("rst_out_sum", ifc.out_sum, 0);
         check("rst_out_row", ifc.out_row, 0);
         check("rst_frame_done", ifc.frame_done, 0);
         check("rst_busy", ifc.busy, 0);
         check("rst_ovf_err", ifc.ovf_err, 0);
      end
      q.delete();
      exp_ovf_nxt = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.in_data   = 8'h00;
      ifc.out_ready = 1'b0;
      do_reset(1'b1);

      rmode = 0;
      send_frame(0, 100, 256, 1'b0);
      drain();
      check("t1_ovf", ifc.ovf_err, 0);

      send_frame(1, 100, 256, 1'b0);
      drain();

      send_frame(0, 40, 256, 1'b1);
      drain();
      check("t3_ovf_trace", ovf_bad, 0);

      rmode = 2;
      send_frame(2, 70, 256, 1'b0);
      send_frame(2, 100, 256, 1'b0);
      drain();
      check("rand_ovf_trace", ovf_bad, 0);

      rmode = 1;
      send_frame(0, 100, 256, 1'b0);
      check("t4_ovf", ifc.ovf_err, 1);
      rmode = 0;
      drain();
      check("t4_ovf_trace", ovf_bad, 0);

      do_reset(1'b0);
      rmode = 3;
      send_frame(0, 100, 80, 1'b0);
      step(1'b0, 8'h00, 1'b0, '0);
      check("t5_ovf", ifc.ovf_err, 0);
      rmode = 0;
      drain();

      do_reset(1'b0);
      send_frame(0, 100, 100, 1'b0);
      do_reset(1'b1);
      send_frame(0, 100, 256, 1'b0);
      drain();
      check("t6_ovf_trace", ovf_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
